// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a valid/ready input, a registered output stage and a
// one-entry skid buffer so one op per cycle is sustained under backpressure.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic [1:0]       occupancy
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; a producer holds valid and its payload stable until accepted.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    logic             skid_valid;
    logic [WIDTH-1:0] skid_result;
    logic             skid_zero;
    logic             skid_illegal;

    logic [WIDTH-1:0] op_result;
    logic             op_illegal;
    logic             op_zero;
    logic             accept;
    logic             deliver;

    always_comb begin
        op_result  = '0;
        op_illegal = 1'b0;
        case (alu_ctrl)
            OP_ADD:  op_result = src_a + src_b;
            OP_SUB:  op_result = src_a - src_b;
            OP_AND:  op_result = src_a & src_b;
            OP_OR:   op_result = src_a | src_b;
            OP_SLT:  op_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: op_illegal = 1'b1;
        endcase
        op_zero = (op_result == '0);
    end

    // in_ready depends only on the skid register (and reset), never on out_ready.
    assign in_ready  = ~skid_valid & ~rst;
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;
    assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            result       <= '0;
            zero         <= 1'b0;
            illegal      <= 1'b0;
            skid_valid   <= 1'b0;
            skid_result  <= '0;
            skid_zero    <= 1'b0;
            skid_illegal <= 1'b0;
        end else if (skid_valid && deliver) begin
            // accept is impossible here because in_ready was low
            out_valid  <= 1'b1;
            result     <= skid_result;
            zero       <= skid_zero;
            illegal    <= skid_illegal;
            skid_valid <= 1'b0;
        end else if (accept && (!out_valid || out_ready)) begin
            out_valid <= 1'b1;
            result    <= op_result;
            zero      <= op_zero;
            illegal   <= op_illegal;
        end else if (accept) begin
            skid_valid   <= 1'b1;
            skid_result  <= op_result;
            skid_zero    <= op_zero;
            skid_illegal <= op_illegal;
        end else if (deliver) begin
            out_valid <= 1'b0;
        end
    end

endmodule
